// File: rtl/writeback_stage_if.sv
// writeback_stage_if: issue, ALU, load and regfile-write signals of the writeback stage.
// WB_BYPASS_EN adds the forwarding outputs.
interface writeback_stage_if #(
    parameter int XLEN  = 32,
    parameter int IDX_W = 5,
    parameter int CNT_W = 32
);
    logic             issue_valid;
    logic [IDX_W-1:0] issue_rd;
    logic [IDX_W-1:0] issue_rs1;
    logic [IDX_W-1:0] issue_rs2;
    logic             issue_stall;
    logic             alu_valid;
    logic [IDX_W-1:0] alu_rd;
    logic [XLEN-1:0]  alu_data;
    logic             alu_ready;
    logic             ld_valid;
    logic [IDX_W-1:0] ld_rd;
    logic [XLEN-1:0]  ld_data;
    logic             ld_ready;
    logic             wb_enable;
    logic [IDX_W-1:0] wb_idx;
    logic [XLEN-1:0]  wb_data;
    logic [CNT_W-1:0] wb_count;
`ifdef WB_BYPASS_EN
    logic             fwd1_hit;
    logic             fwd2_hit;
    logic [XLEN-1:0]  fwd1_data;
    logic [XLEN-1:0]  fwd2_data;
    modport master (
        output issue_valid, issue_rd, issue_rs1, issue_rs2,
        output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
        input  issue_stall, alu_ready, ld_ready, wb_enable, wb_idx, wb_data, wb_count,
        input  fwd1_hit, fwd2_hit, fwd1_data, fwd2_data
    );
    modport slave (
        input  issue_valid, issue_rd, issue_rs1, issue_rs2,
        input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
        output issue_stall, alu_ready, ld_ready, wb_enable, wb_idx, wb_data, wb_count,
        output fwd1_hit, fwd2_hit, fwd1_data, fwd2_data
    );
`else
    modport master (
        output issue_valid, issue_rd, issue_rs1, issue_rs2,
        output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
        input  issue_stall, alu_ready, ld_ready, wb_enable, wb_idx, wb_data, wb_count
    );
    modport slave (
        input  issue_valid, issue_rd, issue_rs1, issue_rs2,
        input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
        output issue_stall, alu_ready, ld_ready, wb_enable, wb_idx, wb_data, wb_count
    );
`endif
endinterface

// File: rtl/writeback_stage.sv
// writeback_stage: load-first arbitration onto the regfile write port, pending-write scoreboard, retire counter.
// Define WB_BYPASS_EN to let a dependent instruction issue in the writeback cycle via forwarding.
module writeback_stage #(
    parameter int XLEN  = 32,
    parameter int IDX_W = 5,
    parameter int CNT_W = 32
) (
    input logic clk,
    input logic rst,
    writeback_stage_if.slave bus
);
    localparam int NREG = 1 << IDX_W;
    logic [NREG-1:0]  pending_q, pending_d, clr_mask, set_mask, eff_pend;
    logic             wb_enable_q, wb_enable_d;
    logic [IDX_W-1:0] wb_idx_q, wb_idx_d;
    logic [XLEN-1:0]  wb_data_q, wb_data_d;
    logic [CNT_W-1:0] wb_count_q, wb_count_d;
    logic             alu_fire, stall, issue_fire;
    always_comb begin
        alu_fire = bus.alu_valid && !bus.ld_valid;
        clr_mask = wb_enable_q ? NREG'(1) << wb_idx_q : '0;
`ifdef WB_BYPASS_EN
        eff_pend = pending_q & ~clr_mask;
`else
        eff_pend = pending_q;
`endif
        // bit 0 of pending is never set, so x0 operands need no explicit check
        stall = bus.issue_valid && (eff_pend[bus.issue_rs1] || eff_pend[bus.issue_rs2] || eff_pend[bus.issue_rd]);
        issue_fire = bus.issue_valid && !stall;
        set_mask = issue_fire ? NREG'(1) << bus.issue_rd : '0;
        pending_d = ((pending_q & ~clr_mask) | set_mask) & ~NREG'(1);
        wb_enable_d = bus.ld_valid ? bus.ld_rd != '0 : alu_fire && bus.alu_rd != '0;
        wb_idx_d = bus.ld_valid ? bus.ld_rd : alu_fire ? bus.alu_rd : wb_idx_q;
        wb_data_d = bus.ld_valid ? bus.ld_data : alu_fire ? bus.alu_data : wb_data_q;
        wb_count_d = wb_count_q + CNT_W'(wb_enable_q);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q   <= '0;
            wb_enable_q <= 1'b0;
            wb_idx_q    <= '0;
            wb_data_q   <= '0;
            wb_count_q  <= '0;
        end else begin
            pending_q   <= pending_d;
            wb_enable_q <= wb_enable_d;
            wb_idx_q    <= wb_idx_d;
            wb_data_q   <= wb_data_d;
            wb_count_q  <= wb_count_d;
        end
    end
    assign bus.ld_ready    = 1'b1;
    assign bus.alu_ready   = !bus.ld_valid;
    assign bus.issue_stall = stall;
    assign bus.wb_enable   = wb_enable_q;
    assign bus.wb_idx      = wb_idx_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.wb_count    = wb_count_q;
`ifdef WB_BYPASS_EN
    assign bus.fwd1_hit  = wb_enable_q && wb_idx_q == bus.issue_rs1 && bus.issue_rs1 != '0;
    assign bus.fwd2_hit  = wb_enable_q && wb_idx_q == bus.issue_rs2 && bus.issue_rs2 != '0;
    assign bus.fwd1_data = wb_data_q;
    assign bus.fwd2_data = wb_data_q;
`endif
endmodule
